// File: rtl/csa_limb_sequencer.sv
`default_nettype none
// ============================================================================
// csa_limb_sequencer: adds two W*LIMBS-bit operands one limb per cycle on an
// external W-bit carry-select adder, rippling the carry between limbs.  Rev 1.0
// ============================================================================
module csa_limb_sequencer #(
  parameter int W     = 64,
  parameter int LIMBS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*LIMBS-1:0]   in_a,
  input  logic [W*LIMBS-1:0]   in_b,
  input  logic                 in_carry_in,
  output logic [W-1:0]         csa_a,
  output logic [W-1:0]         csa_b,
  output logic                 csa_carry_in,
  input  logic [W-1:0]         csa_s,
  input  logic                 csa_carry_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*LIMBS-1:0]   out_sum,
  output logic                 out_carry_out,
  output logic                 busy
);

  localparam int IW = $clog2(LIMBS);
  localparam logic [IW-1:0] C_LAST = IW'(LIMBS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LIMBS-1:0][W-1:0] r_a;
  logic [LIMBS-1:0][W-1:0] r_b;
  logic [LIMBS-1:0][W-1:0] r_sum;
  logic                    r_carry;
  logic [IW-1:0]           r_idx;
  logic                    w_accept;

  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    in_ready      = 1'b0;
    busy          = 1'b0;
    out_valid     = 1'b0;
    out_sum       = '0;
    out_carry_out = 1'b0;
    csa_a         = '0;
    csa_b         = '0;
    csa_carry_in  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        busy         = 1'b1;
        csa_a        = r_a[r_idx];
        csa_b        = r_b[r_idx];
        csa_carry_in = r_carry;
        if (r_idx == C_LAST) w_next = DONE;
      end
      DONE: begin
        busy          = 1'b1;
        out_valid     = 1'b1;
        out_sum       = r_sum;
        out_carry_out = r_carry;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // After the last limb the carry register holds the final carry out.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      if (w_accept) begin
        r_a     <= in_a;
        r_b     <= in_b;
        r_carry <= in_carry_in;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_sum[r_idx] <= csa_s;
        r_carry      <= csa_carry_out;
        if (r_idx != C_LAST) r_idx <= r_idx + IW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csa_limb_sequencer.sv
`default_nettype none
// Testbench for csa_limb_sequencer: behavioural adder plus a scoreboard of
// reference sums pushed at accept and popped when the result appears.
module tb_csa_limb_sequencer;

  localparam int W     = 64;
  localparam int LIMBS = 4;
  localparam int N     = W * LIMBS;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a;
  logic [N-1:0]   in_b;
  logic           in_carry_in;
  logic [W-1:0]   csa_a;
  logic [W-1:0]   csa_b;
  logic           csa_carry_in;
  logic [W-1:0]   csa_s;
  logic           csa_carry_out;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_sum;
  logic           out_carry_out;
  logic           busy;

  int             total = 0;
  int             bad   = 0;
  int             cyc   = 0;
  logic [N:0]     exp_q[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference carry-select adder: purely combinational, same cycle.
  logic [W:0] adder_w;
  assign adder_w       = {1'b0, csa_a} + {1'b0, csa_b} + {{W{1'b0}}, csa_carry_in};
  assign csa_s         = adder_w[W-1:0];
  assign csa_carry_out = adder_w[W];

  csa_limb_sequencer #(.W(W), .LIMBS(LIMBS)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_carry_in  (in_carry_in),
    .csa_a        (csa_a),
    .csa_b        (csa_b),
    .csa_carry_in (csa_carry_in),
    .csa_s        (csa_s),
    .csa_carry_out(csa_carry_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_carry_out(out_carry_out),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [N:0] obs, input logic [N:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one operand pair and wait for it to be accepted.
  task automatic start_txn(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                           input bit keep_valid, output int acc_cyc);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_wait_expired", (n < 50), 1);
    in_a        = a;
    in_b        = b;
    in_carry_in = cin;
    in_valid    = 1'b1;
    tick();
    acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin});
  endtask

  // Called just after the accepting edge; waits for out_valid and checks it.
  task automatic wait_result(output logic [LIMBS-1:0] cins, output logic [N:0] expv);
    int cnt;
    cnt  = 0;
    cins = '0;
    expv = '0;
    while (!out_valid && cnt < 20) begin
      if (cnt < LIMBS) cins[cnt] = csa_carry_in;
      tick();
      cnt++;
    end
    check("latency", cnt, LIMBS);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      expv = exp_q.pop_front();
      check("sum", {out_carry_out, out_sum}, expv);
    end
    check("done_csa_a_zero", {{(N-W+1){1'b0}}, csa_a}, 0);
    check("done_csa_cin_zero", csa_carry_in, 0);
    check("done_in_ready", in_ready, 0);
  endtask

  initial begin
    logic [LIMBS-1:0] cins;
    logic [N:0]       held;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    int               acc;
    int               prev;

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_carry_in = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_csa_a", {{(N-W+1){1'b0}}, csa_a}, 0);
    check("rst_csa_b", {{(N-W+1){1'b0}}, csa_b}, 0);
    check("rst_csa_cin", csa_carry_in, 0);
    check("rst_out_sum", {out_carry_out, out_sum}, 0);
    reset = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // All-ones plus carry-in: carry ripples through every limb.
    start_txn({N{1'b1}}, '0, 1'b1, 1'b0, acc);
    wait_result(cins, held);
    check("ripple_cins", {{(N+1-LIMBS){1'b0}}, cins}, {{(N+1-LIMBS){1'b0}}, 4'b1111});
    check("ripple_const", {out_carry_out, out_sum}, {1'b1, {N{1'b0}}});
    tick();

    start_txn({64'd4, 64'd3, 64'd2, 64'd1}, {64'd40, 64'd30, 64'd20, 64'd10}, 1'b0, 1'b0, acc);
    wait_result(cins, held);
    check("small_const", {out_carry_out, out_sum}, {1'b0, 64'd44, 64'd33, 64'd22, 64'd11});
    tick();

    // Back-pressure in DONE while in_valid toggles.
    out_ready = 1'b0;
    start_txn({4{64'h8000_0000_0000_0001}}, {4{64'h7FFF_FFFF_FFFF_FFFF}}, 1'b1, 1'b0, acc);
    wait_result(cins, held);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = {8{$urandom}};
      tick();
      check("bp_hold_sum", {out_carry_out, out_sum}, held);
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    check("hs_no_accept_busy", busy, 0);
    check("hs_idle_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();

    // Reset during the second RUN cycle aborts the transaction.
    start_txn({8{32'hDEAD_BEEF}}, {8{32'h1234_5678}}, 1'b0, 1'b0, acc);
    tick();
    reset = 1'b0;
    tick();
    void'(exp_q.pop_back());
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("abort_no_valid", out_valid, 0);
    end
    start_txn({8{32'h0F0F_0F0F}}, {8{32'hF0F0_F0F1}}, 1'b0, 1'b0, acc);
    wait_result(cins, held);
    tick();

    // Back-to-back with in_valid and out_ready held high.
    prev = -1;
    for (int t = 0; t < 4; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start_txn(a, b, t[0], 1'b1, acc);
      if (prev >= 0) check("b2b_spacing", acc - prev, LIMBS + 2);
      prev = acc;
      wait_result(cins, held);
    end
    in_valid = 1'b0;
    tick();

    for (int t = 0; t < 1000; t++) begin
      a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (t % 50 == 0) a = {N{1'b1}};
      start_txn(a, b, 1'($urandom_range(0, 1)), 1'b0, acc);
      wait_result(cins, held);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csa_limb_sequencer.md
CSA_LIMB_SEQUENCER -- requirements
Module: csa_limb_sequencer

Interface
REQ-001 SHALL have parameter W, default 64, meaning limb width (matches the carry-select adder width).
REQ-002 SHALL have parameter LIMBS, default 4, meaning number of limbs per operand, >= 2.
REQ-003 clock  input  1  single clock; all logic on posedge clock.
REQ-004 reset  input  1  synchronous, active-low reset (reset==0 resets the block at posedge clock).
REQ-005 in_valid  input  1  upstream operand pair valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 in_a  input  W*LIMBS  operand A, limb 0 in bits [W-1:0].
REQ-008 in_b  input  W*LIMBS  operand B, same limb order.
REQ-009 in_carry_in  input  1  carry into limb 0.
REQ-010 csa_a  output  W  limb of A driven to the carry-select adder.
REQ-011 csa_b  output  W  limb of B driven to the adder.
REQ-012 csa_carry_in  output  1  carry driven to the adder.
REQ-013 csa_s  input  W  adder sum, combinational response to csa_a/csa_b/csa_carry_in in the same cycle.
REQ-014 csa_carry_out  input  1  adder carry out, same-cycle.
REQ-015 out_valid  output  1  result valid.
REQ-016 out_ready  input  1  downstream accepts result.
REQ-017 out_sum  output  W*LIMBS  full-width sum, limb 0 in bits [W-1:0].
REQ-018 out_carry_out  output  1  carry out of the top limb.
REQ-019 busy  output  1  high in RUN or DONE.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, DONE.
REQ-021 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready at a posedge.
REQ-022 On accept: register in_a, in_b; set carry register to in_carry_in; set limb index to 0; enter RUN.
REQ-023 In RUN: csa_a/csa_b SHALL be limb[index] of the registered A/B, and csa_carry_in SHALL be the carry register.
REQ-024 In RUN, each posedge: store csa_s into sum limb[index]; set carry register to csa_carry_out; increment index.
REQ-025 From RUN with index==LIMBS-1: enter DONE after the store; otherwise remain in RUN.
REQ-026 Index width SHALL be $clog2(LIMBS), with no wrap beyond LIMBS-1.
REQ-027 In DONE: out_valid=1; out_sum and out_carry_out are stable and equal (A + B + carry_in) mod 2^(W*LIMBS), plus the final carry.
REQ-028 DONE SHALL hold until out_valid && out_ready, then enter IDLE.
REQ-029 out_valid SHALL rise exactly LIMBS cycles after the accepting posedge; with out_ready held at 1, initiation interval = LIMBS+2 cycles.
REQ-030 In IDLE and DONE: csa_a=0, csa_b=0, csa_carry_in=0.
REQ-031 out_sum and out_carry_out SHALL be 0 outside DONE; in_valid is ignored outside IDLE, and operands are not re-sampled.
REQ-032 Back-pressure: out_ready=0 in DONE SHALL hold all outputs unchanged, for any number of cycles.
REQ-033 Simultaneous in_valid during the DONE handshake SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-034 reset==0 at a posedge SHALL force IDLE, clear the operand, sum, carry and index registers, and abort any RUN/DONE transaction without emitting a result.
REQ-035 During and immediately after reset: in_ready=1 (once reset==1), out_valid=0, busy=0, and all csa_* outputs = 0.
REQ-036 reset has priority over every handshake in the same cycle.

Verification
REQ-037 A=0xFFFF..FF (256 bits), B=0, cin=1 -> out_sum=0, out_carry_out=1; csa_carry_in observed as 1,1,1,1 across RUN.
REQ-038 A=limbs{4,3,2,1}, B=limbs{40,30,20,10}, cin=0 -> out_sum limbs {44,33,22,11}, carry 0, out_valid 4 cycles after accept.
REQ-039 Hold out_ready=0 for 10 cycles in DONE, toggling in_valid -> outputs stable, no second accept, and in_ready=0 throughout.
REQ-040 Assert reset low on the 2nd RUN cycle -> next cycle IDLE, out_valid never asserted, and the next transaction produces a correct result.
REQ-041 Back-to-back transactions with in_valid and out_ready held at 1 -> accepts spaced exactly 6 cycles apart (LIMBS=4).
REQ-042 Random A/B/cin, 1000 transactions -> scoreboard matches the reference sum A+B+cin in every case.
